cache_port_arbiter: RTL and testbench

- Shares the single-ported 32-byte L1 cache core between NUM_REQ requesters, such as fetch, load/store and debug ports.
- Arbitrates round-robin and issues exactly one cache command at a time.
- Models the cache's fixed latencies (hit 1 cycle, miss fill 2 cycles, write-through 2 cycles), because the cache core has no ready/done signal.
- Returns each response tagged with the requester ID.

---
 rtl/cache_arb_pkg.sv | 33 +++
 rtl/cache_port_arbiter_rr_picker.sv | 45 ++++
 rtl/cache_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_cache_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// ---------------------------------------------------------------------------
// cache_arb_pkg
// Shared definitions for the cache port arbiter: default widths, FSM state
// encoding and the fixed cache latencies (accept cycle to response pulse).
// Optional feature macro used by the top: CACHE_ARB_STATS_EN.
// ---------------------------------------------------------------------------
package cache_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int ID_W_DEF    = 2;

  // Cycles from the accept cycle to the rsp_valid cycle.
  localparam int HIT_LAT  = 2;
  localparam int MISS_LAT = 3;
  localparam int WR_LAT   = 3;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ISSUE = 3'd1;
  localparam state_t ST_FILL  = 3'd2;
  localparam state_t ST_STORE = 3'd3;
  localparam state_t ST_RESP  = 3'd4;

  function automatic int lat_for(input logic we, input logic hit);
    if (we)  return WR_LAT;
    if (hit) return HIT_LAT;
    return MISS_LAT;
  endfunction

endpackage

// File: rtl/cache_port_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin pick. The search starts at last_i+1 and wraps
// modulo NUM_REQ, so the requester granted last has the lowest priority.
// Ports:
//   req_i   [NUM_REQ]  pending requests
//   last_i  [ID_W]     index of the previous winner
//   grant_o [NUM_REQ]  one-hot grant (all zero when nothing pending)
//   idx_o   [ID_W]     encoded winner index
//   any_o              at least one request pending
// ---------------------------------------------------------------------------
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  always_comb begin
    logic           found;
    int             cand;
    logic [ID_W-1:0] cand_idx;
    grant_o  = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(last_i) + k) % NUM_REQ;
      cand_idx = ID_W'(cand);
      if (!found && req_i[cand_idx]) begin
        found             = 1'b1;
        grant_o[cand_idx] = 1'b1;
        idx_o             = cand_idx;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/cache_port_arbiter.sv
// ---------------------------------------------------------------------------
// cache_port_arbiter
// Shares one single-ported L1 cache core between NUM_REQ requesters. One
// command is in flight at a time; the cache has no done signal, so its fixed
// latencies are modelled by the FSM path (hit: ISSUE->RESP, read miss:
// ISSUE->FILL->RESP, write: ISSUE->STORE->RESP).
//
// Ports:
//   clk, reset                  clock, async active-high reset
//   req_valid/we [NUM_REQ]      per-requester request and direction
//   req_addr/wdata (packed)     requester i at [i*W +: W]
//   req_accept [NUM_REQ]        one-hot accept pulse (combinational, IDLE)
//   rsp_valid/id/data/hit       one-cycle tagged response
//   cache_addr/wdata/rd/wr      command to the cache core
//   cache_rdata, cache_hit      from the cache core
//   grant_cnt [NUM_REQ*8]       per-requester saturating grant counters
//
// Optional: define CACHE_ARB_STATS_EN to build the grant counters; without
// it grant_cnt is tied to zero.
// ---------------------------------------------------------------------------
module cache_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ID_W    = ID_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]      req_accept,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_hit,
  output logic [ADDR_W-1:0]       cache_addr,
  output logic [DATA_W-1:0]       cache_wdata,
  output logic                    cache_rd,
  output logic                    cache_wr,
  input  logic [DATA_W-1:0]       cache_rdata,
  input  logic                    cache_hit,
  output logic [NUM_REQ*8-1:0]    grant_cnt
);

  state_t              state_q, state_d;
  logic [ID_W-1:0]     last_q;
  logic [ADDR_W-1:0]   cmd_addr_q;
  logic [DATA_W-1:0]   cmd_wdata_q;
  logic                cmd_we_q;
  logic [ID_W-1:0]     cmd_id_q;
  logic                hit_q;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_any;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req_i   (req_valid),
    .last_i  (last_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    req_accept = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          req_accept = pick_grant;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cmd_we_q)       state_d = ST_STORE;
        else if (cache_hit) state_d = ST_RESP;
        else                state_d = ST_FILL;
      end
      ST_FILL,
      ST_STORE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_q      <= ID_W'(NUM_REQ - 1);
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_we_q    <= 1'b0;
      cmd_id_q    <= '0;
      hit_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && pick_any) begin
        cmd_addr_q  <= req_addr[pick_idx*ADDR_W +: ADDR_W];
        cmd_wdata_q <= req_wdata[pick_idx*DATA_W +: DATA_W];
        cmd_we_q    <= req_we[pick_idx];
        cmd_id_q    <= pick_idx;
        last_q      <= pick_idx;
      end
      if (state_q == ST_ISSUE) begin
        hit_q <= cache_hit;
      end
    end
  end

  // Address/data stay on the command registers through FILL/STORE because
  // the cache core uses them again in its second cycle.
  assign cache_addr  = cmd_addr_q;
  assign cache_wdata = cmd_wdata_q;
  assign cache_rd    = (state_q == ST_ISSUE) && !cmd_we_q;
  assign cache_wr    = (state_q == ST_ISSUE) &&  cmd_we_q;

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = rsp_valid ? cmd_id_q : '0;
  assign rsp_hit   = rsp_valid && hit_q;
  assign rsp_data  = (rsp_valid && !cmd_we_q) ? cache_rdata : '0;

`ifdef CACHE_ARB_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
    logic [7:0] cnt_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q <= 8'd0;
      end else if (req_accept[g] && cnt_q != 8'hFF) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
    assign grant_cnt[g*8 +: 8] = cnt_q;
  end
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_port_arbiter.sv
module tb_cache_port_arbiter;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    req_valid;
  logic [3:0]    req_we;
  logic [127:0]  req_addr;
  logic [127:0]  req_wdata;
  logic [3:0]    req_accept;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [31:0]   rsp_data;
  logic          rsp_hit;
  logic [31:0]   cache_addr;
  logic [31:0]   cache_wdata;
  logic          cache_rd;
  logic          cache_wr;
  logic [31:0]   cache_rdata;
  logic          cache_hit;
  logic [31:0]   grant_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int cmd_cnt  = 0;
  bit both_seen = 0;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    logic        hit;
    int          acc_cyc;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  cache_port_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_accept  (req_accept),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .rsp_hit     (rsp_hit),
    .cache_addr  (cache_addr),
    .cache_wdata (cache_wdata),
    .cache_rd    (cache_rd),
    .cache_wr    (cache_wr),
    .cache_rdata (cache_rdata),
    .cache_hit   (cache_hit),
    .grant_cnt   (grant_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Behavioural cache core: hit data after 1 cycle, miss fill after 2,
  // write-through to backing store, no allocate on write miss. Lines are
  // invalidated by the shared reset; the backing store survives it.
  logic        line_v [0:255];
  logic [31:0] line_d [0:255];
  bit   [31:0] wmem   [0:255];
  bit          wvld   [0:255];
  logic        pend;
  logic [7:0]  pend_ix;

  function automatic logic [31:0] bk(input logic [7:0] ix);
    return wvld[ix] ? wmem[ix] : {24'd0, ix};
  endfunction

  assign cache_hit = line_v[cache_addr[7:0]];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) line_v[i] <= 1'b0;
      pend        <= 1'b0;
      pend_ix     <= 8'd0;
      cache_rdata <= 32'd0;
    end else begin
      pend <= 1'b0;
      if (cache_rd) begin
        if (line_v[cache_addr[7:0]]) cache_rdata <= line_d[cache_addr[7:0]];
        else begin
          pend    <= 1'b1;
          pend_ix <= cache_addr[7:0];
        end
      end
      if (pend) begin
        cache_rdata     <= bk(pend_ix);
        line_v[pend_ix] <= 1'b1;
        line_d[pend_ix] <= bk(pend_ix);
      end
      if (cache_wr) begin
        wmem[cache_addr[7:0]] <= cache_wdata;
        wvld[cache_addr[7:0]] <= 1'b1;
        if (line_v[cache_addr[7:0]]) line_d[cache_addr[7:0]] <= cache_wdata;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Response monitor: pops the scoreboard whenever rsp_valid is seen.
  always @(negedge clk) begin
    if (reset) begin
      cmd_cnt = 0;
    end else begin
      if (cache_rd || cache_wr) cmd_cnt++;
      if (cache_rd && cache_wr) both_seen = 1;
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 64'(rsp_id), 64'hFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_id",   64'(rsp_id),   64'(e.id));
          chk("rsp_data", 64'(rsp_data), 64'(e.data));
          chk("rsp_hit",  64'(rsp_hit),  64'(e.hit));
          chk("rsp_lat",  64'(cyc - e.acc_cyc), 64'(e.lat));
          chk("cmds_per_rsp", 64'(cmd_cnt), 64'd1);
        end
        cmd_cnt = 0;
      end
    end
  end

  task automatic set_req(input int id, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    req_valid[id]          = 1'b1;
    req_we[id]             = we;
    req_addr[id*32 +: 32]  = addr;
    req_wdata[id*32 +: 32] = wdata;
  endtask

  // Waits for an accept, checks the winner, optionally queues the expected
  // response, then checks the cache command in the ISSUE cycle.
  task automatic wait_accept(input int id, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] edata,
                             input bit ehit, input int lat, input bit push);
    bit got = 0;
    int n   = 0;
    exp_t e;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (|req_accept) got = 1;
    end
    if (!got) begin
      chk("accept_timeout", 64'(req_accept), 64'(4'b1 << id));
      return;
    end
    chk("accept_onehot", 64'(req_accept), 64'(4'b1 << id));
    if (push) begin
      e.id = 2'(id); e.data = edata; e.hit = ehit; e.acc_cyc = cyc; e.lat = lat;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("issue_rd",   64'(cache_rd),   64'(!we));
    chk("issue_wr",   64'(cache_wr),   64'(we));
    chk("issue_addr", 64'(cache_addr), 64'(addr));
    if (we) chk("issue_wdata", 64'(cache_wdata), 64'(wdata));
  endtask

  task automatic do_req(input int id, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] edata,
                        input bit ehit, input int lat);
    set_req(id, we, addr, wdata);
    wait_accept(id, we, addr, wdata, edata, ehit, lat, 1'b1);
    req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_cache_rd"},  64'(cache_rd),  64'd0);
    chk({tag, "_cache_wr"},  64'(cache_wr),  64'd0);
    chk({tag, "_accept"},    64'(req_accept), 64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    chk("reset_cache_addr", 64'(cache_addr), 64'd0);
    chk("reset_rsp_data",   64'(rsp_data),   64'd0);
    chk("reset_grant_cnt",  64'(grant_cnt),  64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Read miss, read hit, write, read-after-write.
    do_req(0, 1'b0, 32'h10, 32'h0, 32'h10, 1'b0, 3);        drain();
    do_req(0, 1'b0, 32'h10, 32'h0, 32'h10, 1'b1, 2);        drain();
    do_req(1, 1'b1, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0, 3);  drain();
    do_req(2, 1'b0, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0, 3);  drain();

    // Reset pulse so the round-robin pointer starts at requester 0 again.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;

    // All four requesters held valid: grant order 0,1,2,3,0.
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 32'h40 + 32'(4*i), 32'h0);
    for (int k = 0; k < 5; k++) begin
      wait_accept(k % 4, 1'b0, 32'h40 + 32'(4*(k % 4)), 32'h0,
                  32'h40 + 32'(4*(k % 4)), (k == 4), (k == 4) ? 2 : 3, 1'b1);
    end
    req_valid = '0;
    drain();

    // Reset during FILL: request is lost, no response.
    set_req(3, 1'b0, 32'h80, 32'h0);
    wait_accept(3, 1'b0, 32'h80, 32'h0, 32'h80, 1'b0, 3, 1'b0);
    req_valid = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("postreset");
    @(posedge clk); #1;
    do_req(0, 1'b0, 32'h10, 32'h0, 32'h10, 1'b0, 3);        drain();

    // 300 back-to-back grants to requester 3.
    set_req(3, 1'b0, 32'h80, 32'h0);
    for (int k = 0; k < 300; k++) begin
      wait_accept(3, 1'b0, 32'h80, 32'h0, 32'h80, (k != 0), (k == 0) ? 3 : 2, 1'b1);
    end
    req_valid = '0;
    drain();

`ifdef CACHE_ARB_STATS_EN
    chk("grant_cnt3", 64'(grant_cnt[31:24]), 64'd255);
    chk("grant_cnt2", 64'(grant_cnt[23:16]), 64'd0);
    chk("grant_cnt1", 64'(grant_cnt[15:8]),  64'd0);
    chk("grant_cnt0", 64'(grant_cnt[7:0]),   64'd1);
`else
    chk("grant_cnt_off", 64'(grant_cnt), 64'd0);
`endif
    chk("cmd_overlap", 64'(both_seen), 64'd0);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
